ram_block_mover: RTL and testbench

Initiator-side engine for the single-port RAM word interface (address/select/operation/wdata/rdata). Takes one command per handshake: either fill a region with a constant or copy a region from one address to another. Sequences the individual READ/WRITE select pulses itself. Sits between control logic and the ram instance, replacing hand-driven testbench stimulus.

---
 rtl/ram_block_mover.sv | 222 ++++++++++++++++++++++
 tb/tb_ram_block_mover.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_mover.sv
// ram_block_mover: command-driven FILL/COPY engine for a single-port RAM word interface.
// Optional checksum output enabled by defining RAM_MOVER_CHECKSUM_EN.
module ram_block_mover #(
   parameter  int word_size   = 20,
   parameter  int word_amount = 30,
   localparam int AW          = $clog2(word_amount)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_mode,
   input  logic [AW-1:0]        cmd_src,
   input  logic [AW-1:0]        cmd_dst,
   input  logic [AW:0]          cmd_len,
   input  logic [word_size-1:0] cmd_fill,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [AW-1:0]        address,
   output logic                 select,
   output logic                 operation,
   output logic [word_size-1:0] wdata,
   input  logic [word_size-1:0] rdata
`ifdef RAM_MOVER_CHECKSUM_EN
   ,
   output logic [word_size-1:0] checksum
`endif
);

   typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, FIN} state_t;

   localparam logic [AW+1:0] LIMIT = (AW+2)'(word_amount);

   state_t               state_q, state_d;
   logic                 mode_q, mode_d;
   logic [AW-1:0]        src_ptr_q, src_ptr_d;
   logic [AW-1:0]        dst_ptr_q, dst_ptr_d;
   logic [AW:0]          remain_q, remain_d;
   logic [word_size-1:0] fill_q, fill_d;
   logic [word_size-1:0] data_q, data_d;
   logic                 select_q, select_d;
   logic                 operation_q, operation_d;
   logic [AW-1:0]        address_q, address_d;
   logic [word_size-1:0] wdata_q, wdata_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic                 cmd_ready_q, cmd_ready_d;
`ifdef RAM_MOVER_CHECKSUM_EN
   logic [word_size-1:0] checksum_q, checksum_d;
`endif

   logic [AW+1:0] dst_end, src_end;
   logic          range_err;
   logic [AW-1:0] src_inc, dst_inc;

   // Sums are two bits wider than an address so they cannot overflow.
   assign dst_end   = {2'b00, cmd_dst} + {1'b0, cmd_len};
   assign src_end   = {2'b00, cmd_src} + {1'b0, cmd_len};
   assign range_err = (dst_end > LIMIT) || (cmd_mode && (src_end > LIMIT));
   assign src_inc   = src_ptr_q + 1'b1;
   assign dst_inc   = dst_ptr_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      src_ptr_d   = src_ptr_q;
      dst_ptr_d   = dst_ptr_q;
      remain_d    = remain_q;
      fill_d      = fill_q;
      data_d      = data_q;
      select_d    = 1'b0;
      operation_d = operation_q;
      address_d   = address_q;
      wdata_d     = wdata_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      cmd_ready_d = cmd_ready_q;
`ifdef RAM_MOVER_CHECKSUM_EN
      checksum_d  = checksum_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               mode_d      = cmd_mode;
               src_ptr_d   = cmd_src;
               dst_ptr_d   = cmd_dst;
               remain_d    = cmd_len;
               fill_d      = cmd_fill;
               busy_d      = 1'b1;
               cmd_ready_d = 1'b0;
`ifdef RAM_MOVER_CHECKSUM_EN
               checksum_d  = '0;
`endif
               if (range_err) begin
                  state_d = FIN;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else if (cmd_len == '0) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else if (cmd_mode) begin
                  state_d     = RD;
                  select_d    = 1'b1;
                  operation_d = 1'b0;
                  address_d   = cmd_src;
               end else begin
                  state_d     = WR;
                  select_d    = 1'b1;
                  operation_d = 1'b1;
                  address_d   = cmd_dst;
                  wdata_d     = cmd_fill;
               end
            end
         end
         RD: begin
            data_d  = rdata;
            state_d = RD_GAP;
         end
         RD_GAP: begin
            state_d     = WR;
            select_d    = 1'b1;
            operation_d = 1'b1;
            address_d   = dst_ptr_q;
            wdata_d     = data_q;
         end
         WR: begin
            state_d = WR_GAP;
`ifdef RAM_MOVER_CHECKSUM_EN
            checksum_d = checksum_q + wdata_q;
`endif
         end
         WR_GAP: begin
            remain_d  = remain_q - 1'b1;
            src_ptr_d = src_inc;
            dst_ptr_d = dst_inc;
            if (remain_q == (AW+1)'(1)) begin
               state_d = FIN;
               done_d  = 1'b1;
            end else if (mode_q) begin
               state_d     = RD;
               select_d    = 1'b1;
               operation_d = 1'b0;
               address_d   = src_inc;
            end else begin
               state_d     = WR;
               select_d    = 1'b1;
               operation_d = 1'b1;
               address_d   = dst_inc;
               wdata_d     = fill_q;
            end
         end
         FIN: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
         end
         default: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         src_ptr_q   <= '0;
         dst_ptr_q   <= '0;
         remain_q    <= '0;
         fill_q      <= '0;
         data_q      <= '0;
         select_q    <= 1'b0;
         operation_q <= 1'b0;
         address_q   <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cmd_ready_q <= 1'b1;
`ifdef RAM_MOVER_CHECKSUM_EN
         checksum_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         src_ptr_q   <= src_ptr_d;
         dst_ptr_q   <= dst_ptr_d;
         remain_q    <= remain_d;
         fill_q      <= fill_d;
         data_q      <= data_d;
         select_q    <= select_d;
         operation_q <= operation_d;
         address_q   <= address_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         cmd_ready_q <= cmd_ready_d;
`ifdef RAM_MOVER_CHECKSUM_EN
         checksum_q  <= checksum_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign address   = address_q;
   assign select    = select_q;
   assign operation = operation_q;
   assign wdata     = wdata_q;
`ifdef RAM_MOVER_CHECKSUM_EN
   assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_ram_block_mover.sv
// Self-checking bench for ram_block_mover: directed cases plus random FILL/COPY commands
// checked against a word-level memory model and an expected access list.
`timescale 1ns/1ps
module tb_ram_block_mover;
   localparam int WS = 20;
   localparam int WA = 30;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_mode = 1'b0;
   logic [AW-1:0] cmd_src = '0;
   logic [AW-1:0] cmd_dst = '0;
   logic [AW:0]   cmd_len = '0;
   logic [WS-1:0] cmd_fill = '0;
   logic          busy, done, error;
   logic [AW-1:0] address;
   logic          select, operation;
   logic [WS-1:0] wdata, rdata;
`ifdef RAM_MOVER_CHECKSUM_EN
   logic [WS-1:0] checksum;
`endif

   always #5 clk = ~clk;

   ram_block_mover #(.word_size(WS), .word_amount(WA)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
      .busy(busy), .done(done), .error(error),
      .address(address), .select(select), .operation(operation),
      .wdata(wdata), .rdata(rdata)
`ifdef RAM_MOVER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   // Behavioural single-port RAM with a bench-side preload path
   logic [WS-1:0] mem [0:31];
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [WS-1:0] pre_data = '0;
   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (select && operation) mem[address] <= wdata;
   end
   assign rdata = (select && !operation) ? mem[address] : '0;

   typedef struct packed {
      logic          op;
      logic [AW-1:0] addr;
      logic [WS-1:0] data;
   } acc_t;

   acc_t acc_q[$];
   int   gap_viol = 0;
   int   done_cnt = 0;
   logic prev_sel = 1'b0;

   always @(negedge clk) begin
      if (select) acc_q.push_back({operation, address, operation ? wdata : rdata});
      if (select && prev_sel) gap_viol <= gap_viol + 1;
      prev_sel <= select;
      if (done) done_cnt <= done_cnt + 1;
   end

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [WS-1:0] ref_mem [0:WA-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload_all();
      for (int i = 0; i < WA; i++) begin
         @(negedge clk);
         pre_en   = 1'b1;
         pre_addr = AW'(i);
         pre_data = ref_mem[i];
      end
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < WA; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk(tag, 64'(bad), 64'd0);
   endtask

   task automatic run_cmd(input string tag, input logic mode, input logic [AW-1:0] src,
                          input logic [AW-1:0] dst, input logic [AW:0] len, input logic [WS-1:0] fill);
      acc_t          exp_q[$];
      acc_t          e;
      logic          exp_err;
      int            exp_lat, k, start_done;
      logic          got, err_seen, busy_ok;
      logic [WS-1:0] word, exp_sum;

      exp_err = (int'(dst) + int'(len) > WA) || (mode && (int'(src) + int'(len) > WA));
      exp_sum = '0;
      if (!exp_err) begin
         for (int i = 0; i < int'(len); i++) begin
            if (mode) begin
               word   = ref_mem[int'(src) + i];
               e.op   = 1'b0;
               e.addr = AW'(int'(src) + i);
               e.data = word;
               exp_q.push_back(e);
            end else begin
               word = fill;
            end
            e.op   = 1'b1;
            e.addr = AW'(int'(dst) + i);
            e.data = word;
            exp_q.push_back(e);
            ref_mem[int'(dst) + i] = word;
            exp_sum = exp_sum + word;
         end
      end
      exp_lat = (exp_err || len == '0) ? 0 : (mode ? 4 : 2) * int'(len);

      @(negedge clk);
      acc_q.delete();
      start_done = done_cnt;
      cmd_mode  = mode;
      cmd_src   = src;
      cmd_dst   = dst;
      cmd_len   = len;
      cmd_fill  = fill;
      cmd_valid = 1'b1;
      chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      // Keep a garbage command pending while busy; it must be ignored.
      cmd_mode = 1'($urandom);
      cmd_src  = AW'($urandom_range(0, 31));
      cmd_dst  = AW'($urandom_range(0, 31));
      cmd_len  = (AW+1)'($urandom_range(0, 30));
      cmd_fill = WS'($urandom);
      k = 0; got = 1'b0; err_seen = 1'b0; busy_ok = 1'b1;
      while (!got && k < 400) begin
         @(negedge clk);
         if (busy !== 1'b1 || cmd_ready !== 1'b0) busy_ok = 1'b0;
         if (done === 1'b1) begin
            got = 1'b1;
            err_seen = error;
         end else begin
            k++;
         end
      end
      cmd_valid = 1'b0;
      chk({tag, "_done_seen"}, 64'(got), 64'd1);
      chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
      chk({tag, "_error"}, 64'(err_seen), 64'(exp_err));
      chk({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
      $display("cmd %s mode=%0d src=%0d dst=%0d len=%0d fill=%0h -> latency %0d error %0d",
               tag, mode, src, dst, len, fill, k, err_seen);
      @(negedge clk);
      chk({tag, "_done_clear"}, 64'(done), 64'd0);
      chk({tag, "_idle"}, {62'd0, busy, cmd_ready}, 64'd1);
      chk({tag, "_done_count"}, 64'(done_cnt - start_done), 64'd1);
      chk({tag, "_acc_count"}, 64'(acc_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
         chk({tag, "_access"}, 64'(acc_q[i]), 64'(exp_q[i]));
      chk({tag, "_gaps"}, 64'(gap_viol), 64'd0);
`ifdef RAM_MOVER_CHECKSUM_EN
      chk({tag, "_checksum"}, 64'(checksum), 64'(exp_sum));
`endif
      check_mem({tag, "_mem"});
   endtask

   initial begin
      int start_done;
      #12;
      chk("rst_select", 64'(select), 64'd0);
      chk("rst_operation", 64'(operation), 64'd0);
      chk("rst_address", 64'(address), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_flags", {61'd0, busy, done, error}, 64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
`ifdef RAM_MOVER_CHECKSUM_EN
      chk("rst_checksum", 64'(checksum), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < WA; i++) ref_mem[i] = WS'($urandom);
      ref_mem[5] = 20'd11;
      ref_mem[6] = 20'd22;
      preload_all();

      run_cmd("fill_2_3", 1'b0, 5'd2, 5'd2, 6'd3, 20'd17);
      chk("read_addr3", 64'(mem[3]), 64'd17);
      run_cmd("copy_5_20", 1'b1, 5'd5, 5'd20, 6'd2, 20'd0);
      run_cmd("fill_range_err", 1'b0, 5'd0, 5'd28, 6'd3, 20'h5);
      run_cmd("copy_src_err", 1'b1, 5'd29, 5'd0, 6'd2, 20'h0);
      run_cmd("copy_len0", 1'b1, 5'd0, 5'd0, 6'd0, 20'h0);
      run_cmd("fill_full", 1'b0, 5'd0, 5'd0, 6'd30, 20'h12345);
      run_cmd("fill_ffff", 1'b0, 5'd10, 5'd10, 6'd4, 20'hFFFFF);
`ifdef RAM_MOVER_CHECKSUM_EN
      chk("checksum_ffffc", 64'(checksum), 64'hFFFFC);
`endif
      for (int i = 0; i < WA; i++) ref_mem[i] = WS'($urandom);
      preload_all();
      run_cmd("copy_overlap", 1'b1, 5'd3, 5'd4, 6'd5, 20'h0);

      // Reset during the first READ of a COPY: abandoned, no done
      @(negedge clk);
      start_done = done_cnt;
      cmd_mode = 1'b1; cmd_src = 5'd0; cmd_dst = 5'd10; cmd_len = 6'd3; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("rd_cycle", {62'd0, select, operation}, 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_select", 64'(select), 64'd0);
      chk("async_idle", {61'd0, busy, done, cmd_ready}, 64'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abandon_no_done", 64'(done_cnt - start_done), 64'd0);
      $display("reset during COPY read: select=%0d busy=%0d", select, busy);
      check_mem("abandon_mem");
      run_cmd("after_reset", 1'b1, 5'd7, 5'd15, 6'd3, 20'h0);

      for (int n = 0; n < 24; n++) begin
         if (n % 6 == 0) begin
            for (int i = 0; i < WA; i++) ref_mem[i] = WS'($urandom);
            preload_all();
         end
         run_cmd($sformatf("rand%0d", n), 1'($urandom), AW'($urandom_range(0, 31)),
                 AW'($urandom_range(0, 31)), (AW+1)'($urandom_range(0, 10)), WS'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
